// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED pattern sequencer.
//   state_e         : sequencer FSM states (IDLE, RUN, FINISH)
//   entry_t         : one pattern table entry {pattern, hold}
//   prescale_width(): bit width of the prescaler counter for a PRESCALE value
// The entry field widths below are the default NUM_LEDS / HOLD_W of the
// sequencer. A build that overrides those parameters must change these
// widths to match.
// -----------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   localparam int unsigned ENTRY_LED_W  = 32'd4;
   localparam int unsigned ENTRY_HOLD_W = 32'd4;

   typedef struct packed {
      logic [ENTRY_LED_W-1:0]  pattern;
      logic [ENTRY_HOLD_W-1:0] hold;
   } entry_t;

   // Width of a counter running 0..prescale-1, never narrower than one bit.
   function automatic int unsigned prescale_width(input int unsigned prescale);
      if (prescale <= 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(prescale);
      end
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Prescaler that divides clk down to a one-cycle tick every PRESCALE cycles.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset, clears the count
//   clr   in  synchronous clear, holds the count at zero
//   en    in  count enable
//   tick  out high for one cycle when the count is at PRESCALE-1 and en is set
// -----------------------------------------------------------------------------
module led_tick_gen
   import led_pkg::*;
#(
   parameter int unsigned PRESCALE = 32'd5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned       CNT_W   = prescale_width(PRESCALE);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PRESCALE - 32'd1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(32'd1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // The tick is decoded straight from the count so the sequencer sees it in
   // the same cycle the count wraps.
   assign tick = en && (count_q == CNT_MAX);

   // Next count: clear wins, otherwise wrap at CNT_MAX while enabled.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         if (count_q == CNT_MAX) begin
            count_d = '0;
         end else begin
            count_d = count_q + CNT_ONE;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
// Plays a small table of LED patterns; each entry is held for (hold+1)
// prescaled ticks. The table is written through a valid/ready port while idle.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   cfg_valid     table write request (must be held until cfg_ready)
//   cfg_ready     high only in IDLE; write commits when both are high
//   cfg_addr      table entry index
//   cfg_pattern   LED value for the entry
//   cfg_hold      hold count for the entry
//   num_steps     number of entries to play (0..PAT_DEPTH), sampled at start
//   loop_en       wrap to entry 0 after the last entry, sampled at start
//   start         begin playback (level, acted on in IDLE)
//   stop          abort playback, returns to IDLE without done
//   busy          high while playing
//   done          one-cycle pulse on non-looping completion
//   step_idx      index of the entry being shown
//   led           registered LED drive
// -----------------------------------------------------------------------------
module led_pattern_sequencer
   import led_pkg::*;
#(
   parameter int unsigned NUM_LEDS  = ENTRY_LED_W,
   parameter int unsigned PRESCALE  = 32'd5,
   parameter int unsigned PAT_DEPTH = 32'd8,
   parameter int unsigned HOLD_W    = ENTRY_HOLD_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [$clog2(PAT_DEPTH)-1:0] cfg_addr,
   input  logic [NUM_LEDS-1:0]          cfg_pattern,
   input  logic [HOLD_W-1:0]            cfg_hold,
   input  logic [$clog2(PAT_DEPTH):0]   num_steps,
   input  logic                         loop_en,
   input  logic                         start,
   input  logic                         stop,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(PAT_DEPTH)-1:0] step_idx,
   output logic [NUM_LEDS-1:0]          led
);

   localparam int unsigned         IDX_W     = $clog2(PAT_DEPTH);
   localparam logic [IDX_W:0]      STEPS_ONE = (IDX_W + 1)'(32'd1);
   localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(32'd1);
   localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(32'd1);

   // FSM and datapath state
   state_e              state_q,     state_d;
   logic [IDX_W-1:0]    step_idx_q,  step_idx_d;
   logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
   logic [IDX_W:0]      num_steps_q, num_steps_d;
   logic                loop_en_q,   loop_en_d;
   entry_t              table_q [PAT_DEPTH];
   entry_t              table_d [PAT_DEPTH];

   // Registered outputs
   logic [NUM_LEDS-1:0] led_q,       led_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                cfg_ready_q, cfg_ready_d;

   // Combinational helpers
   logic                tick_s;
   logic [HOLD_W-1:0]   cur_hold_s;
   logic                advance_s;
   logic                last_s;
   logic                table_we_s;

   led_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q != ST_RUN),
      .en   (state_q == ST_RUN),
      .tick (tick_s)
   );

   assign cur_hold_s = table_q[step_idx_q].hold;
   // An entry ends on the tick where its hold counter reaches the entry's hold.
   assign advance_s  = tick_s && (hold_cnt_q == cur_hold_s);
   assign last_s     = ({1'b0, step_idx_q} == (num_steps_q - STEPS_ONE));
   // cfg_ready_q is high exactly while the FSM sits in IDLE.
   assign table_we_s = cfg_valid && cfg_ready_q;

   assign cfg_ready = cfg_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign step_idx  = step_idx_q;
   assign led       = led_q;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; stop takes priority over any advance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               if (num_steps != '0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_FINISH;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (advance_s && last_s && !loop_en_q) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Step index, hold counter and run settings for the next cycle.
   always_comb begin
      step_idx_d  = step_idx_q;
      hold_cnt_d  = hold_cnt_q;
      num_steps_d = num_steps_q;
      loop_en_d   = loop_en_q;
      case (state_q)
         ST_IDLE: begin
            step_idx_d = '0;
            hold_cnt_d = '0;
            if (start && !stop) begin
               num_steps_d = num_steps;
               loop_en_d   = loop_en;
            end else begin
               num_steps_d = num_steps_q;
               loop_en_d   = loop_en_q;
            end
         end
         ST_RUN: begin
            if (stop) begin
               step_idx_d = '0;
               hold_cnt_d = '0;
            end else if (advance_s) begin
               hold_cnt_d = '0;
               // Wrapping to 0 on the last entry only matters when looping;
               // otherwise the FSM leaves RUN on this same edge.
               if (last_s) begin
                  step_idx_d = '0;
               end else begin
                  step_idx_d = step_idx_q + IDX_ONE;
               end
            end else if (tick_s) begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
         end
         ST_FINISH: begin
            step_idx_d = '0;
            hold_cnt_d = '0;
         end
         default: begin
            step_idx_d = '0;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Output decode from the next state so every output is a plain flop and the
   // LEDs change on the same edge as the entry.
   always_comb begin
      led_d       = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cfg_ready_d = 1'b0;
      case (state_d)
         ST_IDLE: begin
            cfg_ready_d = 1'b1;
         end
         ST_RUN: begin
            busy_d = 1'b1;
            led_d  = table_q[step_idx_d].pattern;
         end
         ST_FINISH: begin
            done_d = 1'b1;
         end
         default: begin
            cfg_ready_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_idx_q  <= '0;
         hold_cnt_q  <= '0;
         num_steps_q <= '0;
         loop_en_q   <= 1'b0;
         led_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         step_idx_q  <= step_idx_d;
         hold_cnt_q  <= hold_cnt_d;
         num_steps_q <= num_steps_d;
         loop_en_q   <= loop_en_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   // Next table contents: only the addressed entry changes on an accepted write.
   always_comb begin
      table_d = table_q;
      if (table_we_s) begin
         table_d[cfg_addr] = '{pattern: cfg_pattern, hold: cfg_hold};
      end else begin
         table_d = table_q;
      end
   end

   // Pattern table storage; deliberately not reset so it survives rst.
   always_ff @(posedge clk) begin
      table_q <= table_d;
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

   localparam int P = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [2:0] cfg_addr = 3'd0;
   logic [3:0] cfg_pattern = 4'd0;
   logic [3:0] cfg_hold = 4'd0;
   logic [3:0] num_steps = 4'd0;
   logic       loop_en = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       busy;
   logic       done;
   logic [2:0] step_idx;
   logic [3:0] led;

   led_pattern_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_addr    (cfg_addr),
      .cfg_pattern (cfg_pattern),
      .cfg_hold    (cfg_hold),
      .num_steps   (num_steps),
      .loop_en     (loop_en),
      .start       (start),
      .stop        (stop),
      .busy        (busy),
      .done        (done),
      .step_idx    (step_idx),
      .led         (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] led;
      logic       busy;
      logic       done;
      logic       rdy;
      logic [2:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // ---------------- reference model ----------------
   // Playback is modelled as a flat queue of per-cycle (led, index) values.
   int         m_mode = 0;   // 0 idle, 1 playing, 2 finishing
   int         m_pat  [8];
   int         m_hold [8];
   int         m_n    = 0;
   logic       m_loop = 1'b0;
   logic [3:0] m_led  = 4'd0;
   logic [2:0] m_idx  = 3'd0;
   logic [3:0] play_led[$];
   logic [2:0] play_idx[$];

   function automatic void build_play();
      play_led.delete();
      play_idx.delete();
      for (int k = 0; k < m_n; k++)
         for (int c = 0; c < (m_hold[k] + 1) * P; c++) begin
            play_led.push_back(4'(m_pat[k]));
            play_idx.push_back(3'(k));
         end
   endfunction

   function automatic void take();
      m_led = play_led.pop_front();
      m_idx = play_idx.pop_front();
   endfunction

   // Apply current inputs to the model, queue the expected post-edge outputs,
   // then advance one clock.
   task automatic cyc();
      exp_t e;
      if (rst) begin
         m_mode = 0;
         play_led.delete();
         play_idx.delete();
      end else begin
         case (m_mode)
            0: begin
               if (cfg_valid) begin
                  m_pat[cfg_addr]  = int'(cfg_pattern);
                  m_hold[cfg_addr] = int'(cfg_hold);
               end
               if (start && !stop) begin
                  if (num_steps != 4'd0) begin
                     m_n = int'(num_steps);
                     m_loop = loop_en;
                     build_play();
                     take();
                     m_mode = 1;
                  end else begin
                     m_mode = 2;
                  end
               end
            end
            1: begin
               if (stop) m_mode = 0;
               else if (play_led.size() == 0) begin
                  if (m_loop) begin
                     build_play();
                     take();
                  end else begin
                     m_mode = 2;
                  end
               end else begin
                  take();
               end
            end
            default: m_mode = 0;
         endcase
      end
      e.led  = 4'd0;
      e.busy = 1'b0;
      e.done = (m_mode == 2);
      e.rdy  = (m_mode == 0);
      e.idx  = 3'd0;
      if (m_mode == 1) begin
         e.led  = m_led;
         e.busy = 1'b1;
         e.idx  = m_idx;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("led",       32'(led),       32'(mon_e.led));
         chk("busy",      32'(busy),      32'(mon_e.busy));
         chk("done",      32'(done),      32'(mon_e.done));
         chk("cfg_ready", 32'(cfg_ready), 32'(mon_e.rdy));
         chk("step_idx",  32'(step_idx),  32'(mon_e.idx));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic wr(input int a, input int p, input int h);
      cfg_valid = 1'b1;
      cfg_addr = 3'(a); cfg_pattern = 4'(p); cfg_hold = 4'(h);
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic go(input int ns, input logic le);
      num_steps = 4'(ns); loop_en = le;
      cfg_valid = 1'b0; stop = 1'b0; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic do_stop();
      start = 1'b0; cfg_valid = 1'b0; stop = 1'b1;
      cyc();
      stop = 1'b0;
   endtask

   int len;

   initial begin
      #1;
      // reset and table load
      rst = 1'b1; cyc(); cyc();
      rst = 1'b0;
      wr(0, 4'h1, 0); wr(1, 4'h3, 1); wr(2, 4'hF, 0);
      for (int a = 3; a < 8; a++) wr(a, a, 0);
      idle(2);

      // single non-looping run
      go(3, 1'b0); idle(25);

      // looping run, stopped inside entry 1
      go(3, 1'b1); idle(27); do_stop(); idle(3);

      // write held through a run is blocked, then accepted after stop
      go(3, 1'b1);
      cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_pattern = 4'h8; cfg_hold = 4'd0;
      repeat (25) cyc();
      stop = 1'b1; cyc(); stop = 1'b0;
      cyc();
      cfg_valid = 1'b0;
      go(1, 1'b0); idle(8);
      wr(0, 4'h1, 0);

      // num_steps = 0, then start+stop together in idle
      go(0, 1'b0); idle(3);
      num_steps = 4'd3; start = 1'b1; stop = 1'b1; cyc(); cyc();
      start = 1'b0; stop = 1'b0; idle(3);

      // maximum hold: 16 ticks = 80 cycles
      wr(0, 4'hA, 15); go(1, 1'b0); idle(84);
      wr(0, 4'h1, 0);

      // reset during entry 1, then rerun from the retained table
      go(3, 1'b0); idle(8);
      rst = 1'b1; cyc(); rst = 1'b0;
      idle(2); go(3, 1'b0); idle(25);

      // randomized runs
      for (int a = 0; a < 8; a++) wr(a, $urandom_range(0, 15), $urandom_range(0, 3));
      for (int t = 0; t < 12; t++) begin
         go($urandom_range(0, 8), 1'($urandom_range(0, 1)));
         len = $urandom_range(10, 150);
         for (int c = 0; c < len; c++) begin
            stop = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 1) == 1) begin
               cfg_valid = 1'b0;
               start = 1'($urandom_range(0, 1));
            end else begin
               start = 1'b0;
               cfg_valid = 1'($urandom_range(0, 1));
               cfg_addr = 3'($urandom_range(0, 7));
               cfg_pattern = 4'($urandom_range(0, 15));
               cfg_hold = 4'($urandom_range(0, 3));
            end
            cyc();
         end
         do_stop();
         idle(2);
      end

      // let the monitor drain, bounded
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
         @(negedge clk);
         #1;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
